// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register stage with hazard stall,
// flush, and a saturating bubble counter.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   : two-entry stage (main + skid register),
//                                   o_ready registered, no combinational path
//                                   from i_ready/i_stall to o_ready.
//                       undefined : single register, o_ready computed
//                                   combinationally from the downstream side.
//
// All state updates on the rising edge of i_clk; i_reset is synchronous and
// active-high and dominates flush and every transfer.

module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  // FSM encoding kept as plain constants so older tools and waveform
  // scripts that decode the raw value keep working.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] ST_SKID  = 2'd2;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q;
`endif
  logic              up_xfer;
  logic              dn_xfer;
  logic [CNT_W-1:0]  cnt_q;

  // Handshake qualifiers: a stall looks exactly like downstream not ready.
  assign o_valid = (state_q != ST_EMPTY);
  assign dn_xfer = o_valid & i_ready & ~i_stall;
  assign up_xfer = i_valid & o_ready;

`ifdef PIPE_STAGE_SKID_EN
  // Ready is a flop: the skid entry absorbs the one beat that can arrive
  // while downstream backpressure is still propagating upstream.
  assign o_ready = ready_q;
`else
  // Without a skid entry the stage can only take a beat if it is empty or
  // the held beat leaves in the same cycle.
  assign o_ready = ~o_valid | (i_ready & ~i_stall);
`endif

  // The main register is only meaningful while valid; mask it otherwise so
  // the bubble value is guaranteed on the bus.
  assign o_data       = o_valid ? main_q : BUBBLE_DATA;
  assign o_bubble_cnt = cnt_q;

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_DATA;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = BUBBLE_DATA;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_FULL;
            main_d  = i_data;
          end
        end
        ST_FULL: begin
          if (up_xfer && dn_xfer) begin
            // Full throughput: the new beat replaces the departing one.
            main_d = i_data;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_DATA;
`ifdef PIPE_STAGE_SKID_EN
          end else if (up_xfer) begin
            // Downstream blocked but ready was already high: park the beat.
            state_d = ST_SKID;
            skid_d  = i_data;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          // o_ready is low here, so only a drain can happen; the older beat
          // leaves and the parked one moves up, keeping order.
          if (dn_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE_DATA;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_DATA;
        end
      endcase
    end
  end

  // State and main payload register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (i_reset) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid payload register and registered ready.
  always_ff @(posedge i_clk) begin
    // NOTE: the payload registers are reset too, so the bubble value is
    // present from the first edge and no X can leak to o_data.
    if (i_reset) begin
      skid_q  <= BUBBLE_DATA;
      ready_q <= 1'b1;
    end else begin
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_SKID);
    end
  end
`endif

  // Saturating count of cycles with no valid output; flush does not touch it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (!o_valid && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. Builds with or without
// PIPE_STAGE_SKID_EN; the reference model adapts its stage capacity and
// ready rule to the same macro.
//
// Timing per 10-unit cycle (posedge at t):
//   t+1 : driver applies inputs
//   t+5 : monitor (negedge) compares outputs with the model, then retires
//         drained beats / clears on flush or reset
//   t+7 : driver pushes the beat it just issued if the model says it was taken

module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W = 64;
  localparam logic [63:0]       BUB    = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [7:0]        S_BUB  = 8'h5A;

  logic              clk;
  logic              i_reset, i_valid, i_ready, i_stall, i_flush;
  logic [63:0]       i_data;
  logic              o_ready, o_valid;
  logic [63:0]       o_data;
  logic [15:0]       o_bubble_cnt;

  // Small instance used only for counter saturation.
  logic              s_reset, s_valid, s_ready, s_stall, s_flush;
  logic [7:0]        s_data;
  logic              s_o_ready, s_o_valid;
  logic [7:0]        s_o_data;
  logic [1:0]        s_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE_DATA(BUB), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .o_bubble_cnt(o_bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .BUBBLE_DATA(S_BUB), .CNT_W(2)) dut_small (
    .i_clk       (clk),
    .i_reset     (s_reset),
    .i_valid     (s_valid),
    .i_data      (s_data),
    .o_ready     (s_o_ready),
    .o_valid     (s_o_valid),
    .o_data      (s_o_data),
    .i_ready     (s_ready),
    .i_stall     (s_stall),
    .i_flush     (s_flush),
    .o_bubble_cnt(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: beats held by the stage, in arrival order.
  logic [63:0] exp_q[$];
  int          stage_cap;
  logic        m_ready;
  logic        mon_active = 1'b0;
  int unsigned m_cnt = 0;

  initial begin
`ifdef PIPE_STAGE_SKID_EN
    stage_cap = 2;
`else
    stage_cap = 1;
`endif
  end

  // Monitor: compare what the DUT presents, then apply this cycle's drain.
  always @(negedge clk) begin : monitor
    logic        exp_valid;
    logic        exp_ready;
    logic [63:0] exp_data;
    exp_valid = (exp_q.size() != 0);
    exp_data  = exp_valid ? exp_q[0] : BUB;
    if (stage_cap == 2)
      exp_ready = (exp_q.size() < 2);
    else
      exp_ready = !exp_valid || (i_ready && !i_stall);
    m_ready = exp_ready;

    if (mon_active) begin
      check("o_valid", {63'd0, o_valid}, {63'd0, exp_valid});
      check("o_ready", {63'd0, o_ready}, {63'd0, exp_ready});
      check("o_data", o_data, exp_data);
      check("o_bubble_cnt", {48'd0, o_bubble_cnt}, 64'(m_cnt));
    end

    if (i_reset)
      m_cnt = 0;
    else if (!exp_valid && m_cnt < 65535)
      m_cnt = m_cnt + 1;

    if (i_reset || i_flush)
      exp_q.delete();
    else if (exp_valid && i_ready && !i_stall)
      void'(exp_q.pop_front());

    if (i_reset) mon_active = 1'b1;
  end

  // One clock of stimulus; records the beat if the model says it was taken.
  task automatic cyc(input logic v, input logic [63:0] d, input logic rdy,
                     input logic stl, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    i_stall = stl;
    i_flush = fl;
    i_reset = rst;
    #6;
    if (!rst && !fl && v && m_ready) exp_q.push_back(d);
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_data = '0;
    i_ready = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    s_reset = 1'b1; s_valid = 1'b0; s_data = '0;
    s_ready = 1'b1; s_stall = 1'b0; s_flush = 1'b0;

    // Counter saturation on the CNT_W=2 instance (main DUT held in reset).
    @(posedge clk); #1;
    s_reset = 1'b0;
    check("small_cnt_after_reset", {62'd0, s_cnt}, 64'd0);
    check("small_o_data_bubble", {56'd0, s_o_data}, {56'd0, S_BUB});
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check("small_cnt_sat", {62'd0, s_cnt}, 64'((k < 3) ? k : 3));
    end

    // Reset, then idle: bubble count climbs one per empty cycle.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_valid", {63'd0, o_valid}, 64'd0);
    check("post_reset_ready", {63'd0, o_ready}, 64'd1);
    check("post_reset_data", o_data, BUB);
    check("post_reset_cnt", {48'd0, o_bubble_cnt}, 64'd0);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle5_cnt", {48'd0, o_bubble_cnt}, 64'd5);

    // Streaming 1..4 with downstream always ready.
    for (int d = 1; d <= 4; d++) cyc(1'b1, 64'(d), 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: A, B while blocked, then release.
    cyc(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,    1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall holds 0xAA for 3 cycles, then it drains.
    cyc(1'b1, 64'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush while holding two beats, with concurrent beat C.
    cyc(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hC,  1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation while holding two beats.
    cyc(1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0,     1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_reset_valid", {63'd0, o_valid}, 64'd0);
    check("mid_reset_cnt", {48'd0, o_bubble_cnt}, 64'd0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      cyc($urandom_range(0, 9) < 7,
          {$urandom, $urandom},
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 2,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 199) < 1);
    end
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
